ibex_lsu_lite: RTL and testbench
================================

Name: ibex_lsu_lite

Overview:
- Simplified load/store unit sitting directly upstream of the writeback stage.
- Accepts one load/store request from EX and drives the data bus with a req/gnt/rvalid handshake.
- Splits misaligned accesses into two aligned bus transactions, then aligns and sign-extends load data.
- Produces the LSU response and write-back inputs that the writeback stage consumes: rdata, rdata valid, resp valid, resp err.

Parameters:
- None. All widths are fixed at 32-bit address/data and 4-bit byte enables.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
lsu_req_i  in  1  EX requests a memory access (level; sampled only in IDLE)
lsu_we_i  in  1  1 = store, 0 = load
lsu_type_i  in  2  0 = word, 1 = half, 2 = byte (3 = reserved, treated as byte)
lsu_sign_ext_i  in  1  sign-extend load result
lsu_addr_i  in  32  byte address from ALU adder
lsu_wdata_i  in  32  store data, LSB-justified
lsu_req_done_o  out  1  pulse: last transaction granted; EX may retire/advance
lsu_busy_o  out  1  FSM not IDLE
lsu_rdata_o  out  32  aligned, extended load data (to rf_wdata_lsu_i)
lsu_rdata_valid_o  out  1  load data valid this cycle (to rf_we_lsu_i)
lsu_resp_valid_o  out  1  final response this cycle (to lsu_resp_valid_i)
lsu_resp_err_o  out  1  error on any part of access; qualifies resp_valid
data_req_o  out  1  bus request
data_gnt_i  in  1  bus grant
data_rvalid_i  in  1  bus response valid
data_err_i  in  1  bus error, valid with rvalid
data_addr_o  out  32  word-aligned bus address
data_we_o  out  1  bus write enable
data_be_o  out  4  byte enables
data_wdata_o  out  32  lane-rotated store data
data_rdata_i  in  32  bus read data

Behaviour:
- Reset values: all outputs 0; FSM = IDLE; split flag, error flag, rdata_q, and latched request all 0.
- Reset mid-operation returns immediately to IDLE. No response is generated.
- States: IDLE, WAIT_GNT1, WAIT_RV1, WAIT_GNT2, WAIT_RV2.
  - At most one bus transaction outstanding.
  - The second transaction is requested only after the first rvalid.
- IDLE:
  - data_req_o = lsu_req_i, driven combinationally from live inputs.
  - On lsu_req_i, latch addr/type/we/wdata/sign_ext.
  - gnt in the same cycle -> WAIT_RV1; otherwise -> WAIT_GNT1.
- WAIT_GNT1 / WAIT_GNT2:
  - data_req_o = 1 with stable addr/be/we/wdata until gnt.
  - On gnt -> WAIT_RV1 / WAIT_RV2 respectively.
- Split condition, with off = addr[1:0]:
  - word with off != 0, or half with off == 3.
- lsu_req_done_o pulses on the grant of the last transaction:
  - transaction 1 if not split, transaction 2 if split.
- WAIT_RV1 on rvalid:
  - Store rdata into rdata_q; err_q <= data_err_i.
  - Split -> WAIT_GNT2, with data_req_o asserted from the next cycle.
  - Not split -> final response, -> IDLE.
- WAIT_RV2 on rvalid: final response, -> IDLE.
- An err on transaction 1 does not cancel transaction 2.
- Final response (combinational, in the rvalid cycle):
  - lsu_resp_valid_o = 1.
  - lsu_resp_err_o = err_q | data_err_i.
  - lsu_rdata_valid_o = ~we & ~lsu_resp_err_o.
- Bus address:
  - Transaction 1: {addr[31:2], 2'b00}.
  - Transaction 2: {addr[31:2], 2'b00} + 4, wrapping mod 2^32.
- Byte enables:
  - Word: t1 = 4'b1111 << off; t2 = 4'b1111 >> (4 - off).
  - Half: off 0 = 0011, 1 = 0110, 2 = 1100; off 3: t1 = 1000, t2 = 0001.
  - Byte: 0001 << off.
- Store data: data_wdata_o = lsu_wdata_i rotated left by 8*off, for both transactions.
- Load data:
  - raw = ({rdata2, rdata1} >> 8*off)[31:0].
  - rdata1 = rdata_q when split, else data_rdata_i; rdata2 = data_rdata_i.
  - Half: extend raw[15:0] (sign or zero per lsu_sign_ext_i). Byte: extend raw[7:0]. Word: raw.
  - lsu_rdata_o is only meaningful when lsu_rdata_valid_o = 1; otherwise 0.
- Ignored inputs:
  - data_rvalid_i in IDLE or WAIT_GNT* (protocol violation; no state change).
  - lsu_req_i while busy.
- lsu_busy_o = (state != IDLE).

Test Plan:
- Aligned word load, addr 0x100, gnt same cycle, rvalid 2 cycles later with 0xDEADBEEF:
  - data_be = 1111.
  - req_done in cycle 0.
  - resp_valid = rdata_valid = 1 with rdata 0xDEADBEEF.
- Signed byte load, addr 0x203, rdata 0x80FFFFFF:
  - be = 1000; rdata_o = 0xFFFFFF80.
  - Unsigned variant gives 0x00000080.
- Misaligned word load, addr 0x102:
  - t1 addr 0x100 be 1100, rdata 0x3344AAAA.
  - t2 addr 0x104 be 0011, rdata 0xBBBB1122.
  - rdata_o = 0x11223344; exactly one resp_valid; req_done on t2 grant.
- Misaligned half store, addr 0xFFFFFFFF, wdata 0x0000A55A:
  - t1 addr 0xFFFFFFFC be 1000, wdata 0x5A0000A5.
  - t2 addr 0x00000000 (wrap) be 0001.
  - resp_valid = 1, rdata_valid = 0.
- Split load with data_err_i on t1 only:
  - t2 still issued.
  - Final resp_err = 1, rdata_valid = 0.
- gnt held low 5 cycles, then reset asserted in WAIT_RV1:
  - addr/be stable and req high throughout the wait.
  - After reset: all outputs 0, busy 0; a later rvalid produces no response.

Source files
------------

// File: rtl/ibex_lsu_lite.sv
// Simplified load/store unit: one EX request at a time, split into at most two aligned
// bus transactions on a req/gnt/rvalid bus, with load data aligned and extended at the end.
module ibex_lsu_lite (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        lsu_req_i,
   input  logic        lsu_we_i,
   input  logic [1:0]  lsu_type_i,
   input  logic        lsu_sign_ext_i,
   input  logic [31:0] lsu_addr_i,
   input  logic [31:0] lsu_wdata_i,
   output logic        lsu_req_done_o,
   output logic        lsu_busy_o,
   output logic [31:0] lsu_rdata_o,
   output logic        lsu_rdata_valid_o,
   output logic        lsu_resp_valid_o,
   output logic        lsu_resp_err_o,
   output logic        data_req_o,
   input  logic        data_gnt_i,
   input  logic        data_rvalid_i,
   input  logic        data_err_i,
   output logic [31:0] data_addr_o,
   output logic        data_we_o,
   output logic [3:0]  data_be_o,
   output logic [31:0] data_wdata_o,
   input  logic [31:0] data_rdata_i
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_GNT1 = 3'd1,
      WAIT_RV1  = 3'd2,
      WAIT_GNT2 = 3'd3,
      WAIT_RV2  = 3'd4
   } state_e;

   state_e      state_r;
   logic [31:0] addr_r, wdata_r, rdata_r;
   logic [1:0]  type_r;
   logic        we_r, sign_ext_r, split_r, err_r;

   logic [31:0] cur_addr_s, cur_wdata_s, wrot_s, rdata1_s, raw_s, ext_s;
   logic [1:0]  cur_type_s, off_s;
   logic        cur_we_s, cur_split_s, second_s, final_s;

   function automatic logic is_split(input logic [1:0] typ, input logic [1:0] off);
      case (typ)
         2'd0:    is_split = (off != 2'd0);
         2'd1:    is_split = (off == 2'd3);
         default: is_split = 1'b0;
      endcase
   endfunction

   // The access mask is shifted into an 8-lane window; the upper nibble is what spills into word 2.
   function automatic logic [3:0] byte_en(input logic [1:0] typ, input logic [1:0] off,
                                          input logic second);
      logic [7:0] mask;
      case (typ)
         2'd0:    mask = 8'h0F;
         2'd1:    mask = 8'h03;
         default: mask = 8'h01;
      endcase
      mask = mask << off;
      byte_en = second ? mask[7:4] : mask[3:0];
   endfunction

   // In IDLE the bus sees the live EX request so a same-cycle grant works; afterwards the latched copy.
   always_comb begin
      cur_addr_s  = addr_r;
      cur_wdata_s = wdata_r;
      cur_type_s  = type_r;
      cur_we_s    = we_r;
      if (state_r == IDLE) begin
         cur_addr_s  = lsu_addr_i;
         cur_wdata_s = lsu_wdata_i;
         cur_type_s  = lsu_type_i;
         cur_we_s    = lsu_we_i;
      end else begin
         cur_addr_s  = addr_r;
         cur_wdata_s = wdata_r;
         cur_type_s  = type_r;
         cur_we_s    = we_r;
      end
   end

   assign off_s       = cur_addr_s[1:0];
   assign cur_split_s = is_split(cur_type_s, off_s);
   assign second_s    = (state_r == WAIT_GNT2) || (state_r == WAIT_RV2);
   assign wrot_s      = 32'({cur_wdata_s, cur_wdata_s} >> (6'd32 - {1'b0, off_s, 3'b000}));

   // Bus request side and the done pulse on the grant of the final transaction.
   always_comb begin
      data_req_o     = 1'b0;
      lsu_req_done_o = 1'b0;
      case (state_r)
         IDLE: begin
            data_req_o     = lsu_req_i;
            lsu_req_done_o = lsu_req_i & data_gnt_i & ~cur_split_s;
         end
         WAIT_GNT1: begin
            data_req_o     = 1'b1;
            lsu_req_done_o = data_gnt_i & ~split_r;
         end
         WAIT_GNT2: begin
            data_req_o     = 1'b1;
            lsu_req_done_o = data_gnt_i;
         end
         default: begin
            data_req_o     = 1'b0;
            lsu_req_done_o = 1'b0;
         end
      endcase
      if (data_req_o) begin
         data_addr_o  = {cur_addr_s[31:2], 2'b00} + (second_s ? 32'd4 : 32'd0);
         data_we_o    = cur_we_s;
         data_be_o    = byte_en(cur_type_s, off_s, second_s);
         data_wdata_o = wrot_s;
      end else begin
         data_addr_o  = 32'd0;
         data_we_o    = 1'b0;
         data_be_o    = 4'd0;
         data_wdata_o = 32'd0;
      end
   end

   assign rdata1_s = split_r ? rdata_r : data_rdata_i;
   assign raw_s    = 32'({data_rdata_i, rdata1_s} >> {addr_r[1:0], 3'b000});
   assign final_s  = data_rvalid_i &
                     (((state_r == WAIT_RV1) & ~split_r) | (state_r == WAIT_RV2));

   // Load data extension by access size.
   always_comb begin
      ext_s = raw_s;
      case (type_r)
         2'd0:    ext_s = raw_s;
         2'd1:    ext_s = {{16{sign_ext_r & raw_s[15]}}, raw_s[15:0]};
         default: ext_s = {{24{sign_ext_r & raw_s[7]}}, raw_s[7:0]};
      endcase
   end

   assign lsu_resp_valid_o  = final_s;
   assign lsu_resp_err_o    = final_s & (err_r | data_err_i);
   assign lsu_rdata_valid_o = final_s & ~we_r & ~lsu_resp_err_o;
   assign lsu_rdata_o       = lsu_rdata_valid_o ? ext_s : 32'd0;
   assign lsu_busy_o        = (state_r != IDLE);

   // Transaction sequencer: latch the request, then walk one or two grant/rvalid pairs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r    <= IDLE;
         addr_r     <= 32'd0;
         wdata_r    <= 32'd0;
         rdata_r    <= 32'd0;
         type_r     <= 2'd0;
         we_r       <= 1'b0;
         sign_ext_r <= 1'b0;
         split_r    <= 1'b0;
         err_r      <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (lsu_req_i) begin
                  addr_r     <= lsu_addr_i;
                  wdata_r    <= lsu_wdata_i;
                  type_r     <= lsu_type_i;
                  we_r       <= lsu_we_i;
                  sign_ext_r <= lsu_sign_ext_i;
                  split_r    <= cur_split_s;
                  err_r      <= 1'b0;
                  state_r    <= data_gnt_i ? WAIT_RV1 : WAIT_GNT1;
               end
            end
            WAIT_GNT1: if (data_gnt_i) state_r <= WAIT_RV1;
            WAIT_RV1: begin
               if (data_rvalid_i) begin
                  rdata_r <= data_rdata_i;
                  err_r   <= data_err_i;
                  state_r <= split_r ? WAIT_GNT2 : IDLE;
               end
            end
            WAIT_GNT2: if (data_gnt_i) state_r <= WAIT_RV2;
            WAIT_RV2:  if (data_rvalid_i) state_r <= IDLE;
            default:   state_r <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ibex_lsu_lite.sv
// Bench for ibex_lsu_lite: directed scenarios plus randomized accesses, each checked against
// a byte-level model of which bytes an access touches and how they land in lanes.
module tb_ibex_lsu_lite;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic        lsu_req = 1'b0, lsu_we = 1'b0, lsu_sext = 1'b0;
   logic [1:0]  lsu_type = 2'd0;
   logic [31:0] lsu_addr = 32'd0, lsu_wdata = 32'd0;
   logic        req_done, busy, rdata_valid, resp_valid, resp_err;
   logic [31:0] rdata;
   logic        data_req, data_we;
   logic        data_gnt = 1'b0, data_rvalid = 1'b0, data_err = 1'b0;
   logic [31:0] data_addr, data_wdata;
   logic [31:0] data_rdata = 32'd0;
   logic [3:0]  data_be;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   ibex_lsu_lite dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .lsu_req_i(lsu_req), .lsu_we_i(lsu_we), .lsu_type_i(lsu_type),
      .lsu_sign_ext_i(lsu_sext), .lsu_addr_i(lsu_addr), .lsu_wdata_i(lsu_wdata),
      .lsu_req_done_o(req_done), .lsu_busy_o(busy), .lsu_rdata_o(rdata),
      .lsu_rdata_valid_o(rdata_valid), .lsu_resp_valid_o(resp_valid), .lsu_resp_err_o(resp_err),
      .data_req_o(data_req), .data_gnt_i(data_gnt), .data_rvalid_i(data_rvalid),
      .data_err_i(data_err), .data_addr_o(data_addr), .data_we_o(data_we),
      .data_be_o(data_be), .data_wdata_o(data_wdata), .data_rdata_i(data_rdata)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_req"}, {31'd0, data_req}, 32'd0);
      check({tag, "_addr"}, data_addr, 32'd0);
      check({tag, "_we"}, {31'd0, data_we}, 32'd0);
      check({tag, "_be"}, {28'd0, data_be}, 32'd0);
      check({tag, "_wdata"}, data_wdata, 32'd0);
      check({tag, "_done"}, {31'd0, req_done}, 32'd0);
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
      check({tag, "_rdata"}, rdata, 32'd0);
      check({tag, "_rdv"}, {31'd0, rdata_valid}, 32'd0);
      check({tag, "_rspv"}, {31'd0, resp_valid}, 32'd0);
      check({tag, "_rsperr"}, {31'd0, resp_err}, 32'd0);
   endtask

   // One complete access: the bench plays the bus slave; rd1/rd2 are the words returned.
   // Entered and left just after a rising edge.
   task automatic do_access(input logic we, input logic [1:0] typ, input logic sext,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rd1, input logic [31:0] rd2,
                            input int gdly, input int rdly, input logic e1, input logic e2);
      int          n, off, nt, p;
      logic [31:0] base, rel, exp_wd, exp_ld, w, byt;
      logic [3:0]  exp_be;
      logic        exp_err;
      n   = (typ == 2'd0) ? 4 : ((typ == 2'd1) ? 2 : 1);
      off = int'(addr[1:0]);
      nt  = (off + n > 4) ? 2 : 1;
      exp_err = e1 | ((nt == 2) ? e2 : 1'b0);
      exp_ld  = 32'd0;
      for (int i = 0; i < n; i++) begin
         p   = off + i;
         w   = (p < 4) ? rd1 : rd2;
         byt = (w >> (8 * (p % 4))) & 32'hFF;
         exp_ld = exp_ld | (byt << (8 * i));
      end
      if (sext && n == 2 && exp_ld[15]) exp_ld = exp_ld | 32'hFFFF0000;
      if (sext && n == 1 && exp_ld[7])  exp_ld = exp_ld | 32'hFFFFFF00;
      exp_wd = 32'd0;
      for (int j = 0; j < 4; j++) begin
         byt    = (wdata >> (8 * ((j - off + 4) % 4))) & 32'hFF;
         exp_wd = exp_wd | (byt << (8 * j));
      end
      lsu_req = 1'b1; lsu_we = we; lsu_type = typ; lsu_sext = sext;
      lsu_addr = addr; lsu_wdata = wdata;
      for (int k = 0; k < nt; k++) begin
         base = {addr[31:2], 2'b00} + 32'(4 * k);
         for (int j = 0; j < 4; j++) begin
            rel = base + 32'(j) - addr;
            exp_be[j] = (rel < 32'(n));
         end
         for (int c = 0; c <= gdly; c++) begin
            data_gnt    = (c == gdly);
            data_rvalid = 1'($urandom_range(0, 1));
            data_err    = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("g_req", {31'd0, data_req}, 32'd1);
            check("g_addr", data_addr, base);
            check("g_be", {28'd0, data_be}, {28'd0, exp_be});
            check("g_we", {31'd0, data_we}, {31'd0, we});
            check("g_wdata", data_wdata, exp_wd);
            check("g_busy", {31'd0, busy}, (k == 0 && c == 0) ? 32'd0 : 32'd1);
            check("g_done", {31'd0, req_done}, (c == gdly && k == nt - 1) ? 32'd1 : 32'd0);
            check("g_rspv", {31'd0, resp_valid}, 32'd0);
            @(posedge clk); #1;
            lsu_req = 1'($urandom_range(0, 1));
            lsu_addr = $urandom; lsu_wdata = $urandom; lsu_we = 1'($urandom_range(0, 1));
            lsu_type = 2'($urandom_range(0, 3)); lsu_sext = 1'($urandom_range(0, 1));
         end
         data_gnt = 1'b0;
         for (int c = 0; c <= rdly; c++) begin
            data_rvalid = (c == rdly);
            data_rdata  = (c == rdly) ? ((k == 0) ? rd1 : rd2) : $urandom;
            data_err    = (c == rdly) ? ((k == 0) ? e1 : e2) : 1'($urandom_range(0, 1));
            @(negedge clk);
            check("r_req", {31'd0, data_req}, 32'd0);
            check("r_busy", {31'd0, busy}, 32'd1);
            check("r_done", {31'd0, req_done}, 32'd0);
            if (c == rdly && k == nt - 1) begin
               check("r_rspv", {31'd0, resp_valid}, 32'd1);
               check("r_rsperr", {31'd0, resp_err}, {31'd0, exp_err});
               check("r_rdv", {31'd0, rdata_valid}, {31'd0, ~we & ~exp_err});
               check("r_rdata", rdata, (~we & ~exp_err) ? exp_ld : 32'd0);
            end else begin
               check("r_rspv0", {31'd0, resp_valid}, 32'd0);
               check("r_rdv0", {31'd0, rdata_valid}, 32'd0);
               check("r_rdata0", rdata, 32'd0);
            end
            @(posedge clk); #1;
         end
         data_rvalid = 1'b0; data_err = 1'b0;
      end
      lsu_req = 1'b0;
      @(negedge clk);
      check("end_busy", {31'd0, busy}, 32'd0);
      check("end_rspv", {31'd0, resp_valid}, 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      #2;
      check_all_zero("por");
      @(posedge clk); @(posedge clk); #1;
      rst_ni = 1'b1;
      @(posedge clk); #1;

      // aligned word load, same-cycle grant
      do_access(1'b0, 2'd0, 1'b0, 32'h100, 32'd0, 32'hDEADBEEF, 32'd0, 0, 1, 1'b0, 1'b0);
      // signed and unsigned byte load at lane 3
      do_access(1'b0, 2'd2, 1'b1, 32'h203, 32'd0, 32'h80FFFFFF, 32'd0, 0, 0, 1'b0, 1'b0);
      do_access(1'b0, 2'd2, 1'b0, 32'h203, 32'd0, 32'h80FFFFFF, 32'd0, 1, 0, 1'b0, 1'b0);
      // misaligned word load across two words
      do_access(1'b0, 2'd0, 1'b0, 32'h102, 32'd0, 32'h3344AAAA, 32'hBBBB1122, 0, 1, 1'b0, 1'b0);
      // misaligned half store wrapping the address space
      do_access(1'b1, 2'd1, 1'b0, 32'hFFFFFFFF, 32'h0000A55A, 32'd0, 32'd0, 1, 0, 1'b0, 1'b0);
      // split load with an error on the first half only
      do_access(1'b0, 2'd0, 1'b1, 32'h1001, 32'd0, 32'h11111111, 32'h22222222, 0, 0, 1'b1, 1'b0);
      // reserved type behaves as a byte
      do_access(1'b0, 2'd3, 1'b1, 32'h402, 32'd0, 32'h00F10000, 32'd0, 0, 0, 1'b0, 1'b0);

      for (int t = 0; t < 40; t++) begin
         do_access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   $urandom, $urandom, $urandom, $urandom,
                   $urandom_range(0, 2), $urandom_range(0, 2),
                   ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
      end

      // grant withheld 5 cycles, then reset while waiting for rvalid
      lsu_req = 1'b1; lsu_we = 1'b0; lsu_type = 2'd0; lsu_addr = 32'h340; data_gnt = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         check("hold_req", {31'd0, data_req}, 32'd1);
         check("hold_addr", data_addr, 32'h340);
         check("hold_be", {28'd0, data_be}, 32'hF);
         check("hold_done", {31'd0, req_done}, (c == 5) ? 32'd1 : 32'd0);
         @(posedge clk); #1;
         lsu_req = 1'b0; lsu_addr = $urandom;
         data_gnt = (c == 4);
      end
      data_gnt = 1'b0;
      @(negedge clk);
      check("rv1_busy", {31'd0, busy}, 32'd1);
      rst_ni = 1'b0;
      #1;
      check_all_zero("mid_rst");
      @(posedge clk); #1;
      rst_ni = 1'b1;
      data_rvalid = 1'b1; data_rdata = 32'h12345678;
      @(negedge clk);
      check("post_rst_rspv", {31'd0, resp_valid}, 32'd0);
      check("post_rst_rdv", {31'd0, rdata_valid}, 32'd0);
      check("post_rst_busy", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
      data_rvalid = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
